// File: rtl/cia_pkg.sv
// Shared CIA time-of-day field widths and digit terminal counts.
// Imported by the TOD cell wrapper; the leaf cells themselves stay package-free.
package cia_pkg;

  localparam int DEC_N    = 9;
  localparam int SEXA_N   = 5;
  localparam int HR12_N   = 2;
  localparam int SEXA_W   = 3;
  localparam int HR_CNT_W = 4;

  typedef logic [3:0] tenths_t;
  typedef logic [3:0] sec_lo_t;
  typedef logic [2:0] sec_hi_t;
  typedef logic [3:0] min_lo_t;
  typedef logic [2:0] min_hi_t;
  typedef logic [3:0] hr_lo_t;
  typedef logic [0:0] hr_hi_t;

  // The 12-hour tens digit counts in a 4-bit field so the out-of-range hour bug is reproduced.
  typedef logic [HR_CNT_W-1:0] hr_cnt_t;

  typedef struct packed {
    logic   pm;
    hr_hi_t hi;
    hr_lo_t lo;
  } tod_hr_t;

endpackage

// File: rtl/bcd_update.sv
// Single BCD digit next-value/carry generator; load beats increment, exact-equality terminal count.
// Combinational, zero latency; no backpressure.
module bcd_update #(
  parameter int N = 9,
  parameter int W = $clog2(N+1)
) (
  input  logic         we,
  input  logic [W-1:0] data,
  input  logic [W-1:0] value,
  input  logic         cin,
  output logic [W-1:0] next,
  output logic         cout
);

  always_comb begin
    next = value;
    cout = 1'b0;
    if (we) begin
      next = data;
    end else if (cin) begin
      // Exact match only: values past N keep counting and wrap at 2^W without carrying.
      if (value == W'(N)) begin
        next = '0;
        cout = 1'b1;
      end else begin
        next = value + W'(1);
      end
    end
  end

endmodule

// File: rtl/cia_edgedet.sv
// Strobe-sampled rising-edge detector for the TOD pad; output held one full sample period.
// Optional EDGEDET_SYNC_EN adds a free-running pad synchronizer (one extra clk of latency).
module cia_edgedet (
  input  logic clk,
  input  logic res,
  input  logic phi2_dn,
  input  logic pad_i,
  output logic posedge_o
);

  logic pad_s;
  logic s_cur;
  logic s_prev;

`ifdef EDGEDET_SYNC_EN
  logic pad_sync;

  always_ff @(posedge clk) begin
    if (res) pad_sync <= 1'b0;
    else     pad_sync <= pad_i;
  end

  assign pad_s = pad_sync;
`else
  assign pad_s = pad_i;
`endif

  always_ff @(posedge clk) begin
    if (res) begin
      s_cur  <= 1'b0;
      s_prev <= 1'b0;
    end else if (phi2_dn) begin
      s_cur  <= pad_s;
      s_prev <= s_cur;
    end
  end

  assign posedge_o = s_cur & ~s_prev;

endmodule

// File: rtl/cia_tod_cells.sv
// TOD cell slice: decimal, base-6 and 12-hour-tens digit generators plus the pad edge detector.
// Digits are combinational; edge output follows the phi2_dn strobe (EDGEDET_SYNC_EN adds one clk).
module cia_tod_cells
  import cia_pkg::*;
(
  input  logic    clk,
  input  logic    res,
  input  logic    phi2_dn,
  input  logic    pad_i,
  output logic    posedge_o,

  input  logic    d9_we,
  input  tenths_t d9_data,
  input  tenths_t d9_value,
  input  logic    d9_cin,
  output tenths_t d9_next,
  output logic    d9_cout,

  input  logic    d5_we,
  input  sec_hi_t d5_data,
  input  sec_hi_t d5_value,
  input  logic    d5_cin,
  output sec_hi_t d5_next,
  output logic    d5_cout,

  input  logic    d2_we,
  input  hr_cnt_t d2_data,
  input  hr_cnt_t d2_value,
  input  logic    d2_cin,
  output hr_cnt_t d2_next,
  output logic    d2_cout
);

  bcd_update #(.N(DEC_N)) u_dec (
    .we(d9_we), .data(d9_data), .value(d9_value), .cin(d9_cin),
    .next(d9_next), .cout(d9_cout)
  );

  bcd_update #(.N(SEXA_N), .W(SEXA_W)) u_sexa (
    .we(d5_we), .data(d5_data), .value(d5_value), .cin(d5_cin),
    .next(d5_next), .cout(d5_cout)
  );

  bcd_update #(.N(HR12_N), .W(HR_CNT_W)) u_hr12 (
    .we(d2_we), .data(d2_data), .value(d2_value), .cin(d2_cin),
    .next(d2_next), .cout(d2_cout)
  );

  cia_edgedet u_edge (
    .clk(clk), .res(res), .phi2_dn(phi2_dn), .pad_i(pad_i), .posedge_o(posedge_o)
  );

endmodule

// File: tb/tb_cia_tod_cells.sv
// Bench for cia_tod_cells: digit rules from plain arithmetic, edge detector from a sample history.
module tb_cia_tod_cells;

`ifdef EDGEDET_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic res = 1'b1, phi2_dn = 1'b0, pad_i = 1'b0, posedge_o;
  logic d9_we = 0, d9_cin = 0, d9_cout;
  logic [3:0] d9_data = 0, d9_value = 0, d9_next;
  logic d5_we = 0, d5_cin = 0, d5_cout;
  logic [2:0] d5_data = 0, d5_value = 0, d5_next;
  logic d2_we = 0, d2_cin = 0, d2_cout;
  logic [3:0] d2_data = 0, d2_value = 0, d2_next;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int hi_cnt;
  bit samp[$];
  bit pd = 1'b0;

  cia_tod_cells dut (
    .clk(clk), .res(res), .phi2_dn(phi2_dn), .pad_i(pad_i), .posedge_o(posedge_o),
    .d9_we(d9_we), .d9_data(d9_data), .d9_value(d9_value), .d9_cin(d9_cin),
    .d9_next(d9_next), .d9_cout(d9_cout),
    .d5_we(d5_we), .d5_data(d5_data), .d5_value(d5_value), .d5_cin(d5_cin),
    .d5_next(d5_next), .d5_cout(d5_cout),
    .d2_we(d2_we), .d2_data(d2_data), .d2_value(d2_value), .d2_cin(d2_cin),
    .d2_next(d2_next), .d2_cout(d2_cout)
  );

  function automatic void bcd_ref(input int n, input int w, input int we, input int data,
                                  input int value, input int cin, output int nx, output int co);
    int m;
    m = 1 << w;
    if (we != 0) begin
      nx = data % m; co = 0;
    end else if (cin != 0) begin
      if (value == n) begin nx = 0; co = 1; end
      else begin nx = (value + 1) % m; co = 0; end
    end else begin
      nx = value; co = 0;
    end
  endfunction

  function automatic bit exp_edge();
    int n;
    n = samp.size();
    if (n == 0) return 1'b0;
    if (n == 1) return samp[0];
    return samp[n-1] & ~samp[n-2];
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic bcd_vec(input int w9, input int a9, input int v9, input int c9,
                         input int w5, input int a5, input int v5, input int c5,
                         input int w2, input int a2, input int v2, input int c2);
    int nx, co;
    d9_we = w9[0]; d9_data = a9[3:0]; d9_value = v9[3:0]; d9_cin = c9[0];
    d5_we = w5[0]; d5_data = a5[2:0]; d5_value = v5[2:0]; d5_cin = c5[0];
    d2_we = w2[0]; d2_data = a2[3:0]; d2_value = v2[3:0]; d2_cin = c2[0];
    #1;
    bcd_ref(9, 4, w9, a9, v9, c9, nx, co);
    chk("d9_next", d9_next, nx[3:0]);
    chk("d9_cout", {3'b0, d9_cout}, co[3:0]);
    bcd_ref(5, 3, w5, a5, v5, c5, nx, co);
    chk("d5_next", {1'b0, d5_next}, nx[3:0]);
    chk("d5_cout", {3'b0, d5_cout}, co[3:0]);
    bcd_ref(2, 4, w2, a2, v2, c2, nx, co);
    chk("d2_next", d2_next, nx[3:0]);
    chk("d2_cout", {3'b0, d2_cout}, co[3:0]);
  endtask

  // One clk: strobe every 4th cycle, model updated from the inputs present at the edge.
  task automatic step();
    bit v;
    phi2_dn = ((cyc % 4) == 3);
    @(posedge clk);
    if (res) begin
      samp.delete();
      pd = 1'b0;
    end else begin
      v = SYNC ? pd : pad_i;
      if (phi2_dn) samp.push_back(v);
      if (samp.size() > 2) void'(samp.pop_front());
      pd = pad_i;
    end
    cyc++;
    #1;
    chk("posedge_o", {3'b0, posedge_o}, {3'b0, exp_edge()});
    if (posedge_o === 1'b1) hi_cnt++;
  endtask

  initial begin
    // Digit directed vectors
    bcd_vec(0, 0, 9, 1,  1, 3, 5, 1,  0, 0, 2, 1);
    bcd_vec(0, 0, 4, 1,  0, 0, 5, 1,  0, 0, 9, 1);
    bcd_vec(0, 0, 7, 0,  0, 0, 4, 1,  0, 0, 15, 1);
    bcd_vec(1, 6, 9, 1,  0, 0, 7, 1,  1, 12, 2, 1);
    bcd_vec(0, 0, 15, 1, 0, 0, 3, 0,  0, 0, 1, 1);
    for (int i = 0; i < 200; i++) begin
      bcd_vec($urandom_range(0, 3) == 0, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1),
              $urandom_range(0, 3) == 0, $urandom_range(0, 7),  $urandom_range(0, 7),  $urandom_range(0, 1),
              $urandom_range(0, 3) == 0, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
    end

    // Edge detector: reset state, then random pad/reset traffic
    res = 1'b1;
    step(); step();
    res = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) pad_i = ~pad_i;
      res = ($urandom_range(0, 60) == 0);
      step();
    end

    // Clean rising edge: high for exactly one sample period, then nothing while held high
    res = 1'b1; pad_i = 1'b0;
    step();
    res = 1'b0;
    for (int i = 0; i < 12; i++) step();
    pad_i = 1'b1;
    hi_cnt = 0;
    for (int i = 0; i < 24; i++) step();
    chk("pulse_width", hi_cnt[3:0], 4'd4);
    hi_cnt = 0;
    for (int i = 0; i < 24; i++) step();
    chk("held_high_no_pulse", hi_cnt[3:0], 4'd0);

    // Glitch between strobes is not seen
    pad_i = 1'b0;
    for (int i = 0; i < 12; i++) step();
    while ((cyc % 4) != 0) step();
    hi_cnt = 0;
    pad_i = 1'b1; step();
    pad_i = 1'b0; step();
    for (int i = 0; i < 16; i++) step();
    chk("glitch_no_pulse", hi_cnt[3:0], 4'd0);

    // Reset mid-pulse clears the output on the next clk
    pad_i = 1'b1;
    begin
      int k;
      k = 0;
      while (posedge_o !== 1'b1 && k < 20) begin step(); k++; end
      chk("pulse_seen", {3'b0, posedge_o}, 4'd1);
    end
    res = 1'b1;
    step();
    chk("res_mid_pulse", {3'b0, posedge_o}, 4'd0);
    res = 1'b0;
    for (int i = 0; i < 8; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
